// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants for the processor I/O port bank.
// Default port geometry and the port-index width helper.
package io_port_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NUM_PORTS = 4;

    // Port index width, never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_in_channel.sv
// io_in_channel: one input port capture channel.
// Strobe synchroniser, rise detect, data latch, full and overrun flags.
module io_in_channel
    import io_port_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              strobe_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_i,
    input  logic              clr_err_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              overrun_o
);

    logic [2:0]        sync_q;
    logic              rise;
    logic [DATA_W-1:0] lat_q, lat_d;
    logic              full_q, full_d;
    logic              ovr_q, ovr_d;

    // Two synchroniser stages plus one history stage for edge detect.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], strobe_i};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

    // Capture beats read; a new overrun beats the clear.
    always_comb begin
        lat_d  = lat_q;
        full_d = full_q;
        ovr_d  = clr_err_i ? 1'b0 : ovr_q;
        if (rise) begin
            lat_d  = data_i;
            full_d = 1'b1;
            if (full_q && !rd_i) begin
                ovr_d = 1'b1;
            end
        end else if (rd_i) begin
            full_d = 1'b0;
        end
    end

    // Latch and flag registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            lat_q  <= '0;
            full_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            lat_q  <= lat_d;
            full_q <= full_d;
            ovr_q  <= ovr_d;
        end
    end

    assign data_o    = lat_q;
    assign full_o    = full_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: parametrised processor-facing I/O port bank.
// Input capture channels, output registers with valid/ack handshake.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int SEL_W     = sel_w(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic [SEL_W-1:0]            PortSel,
    input  logic                        INportRead,
    input  logic                        OUTportWrite,
    input  logic [DATA_W-1:0]           WriteData,
    output logic [DATA_W-1:0]           ReadData,
    output logic                        Busy,
    input  logic                        ClrErr,
    input  logic [NUM_PORTS*DATA_W-1:0] InpExtWorld,
    input  logic [NUM_PORTS-1:0]        InpStrobe,
    output logic [NUM_PORTS-1:0]        InFull,
    output logic [NUM_PORTS-1:0]        InOverrun,
    output logic [NUM_PORTS*DATA_W-1:0] OutExtWorld,
    output logic [NUM_PORTS-1:0]        OutValid,
    input  logic [NUM_PORTS-1:0]        OutAck,
    output logic [NUM_PORTS-1:0]        OutDrop
);

    logic [DATA_W-1:0]           lat [NUM_PORTS];
    logic [NUM_PORTS-1:0]        rd_hit;
    logic [DATA_W-1:0]           rdata_q, rdata_d;
    logic [NUM_PORTS*DATA_W-1:0] out_q, out_d;
    logic [NUM_PORTS-1:0]        valid_q, valid_d;
    logic [NUM_PORTS-1:0]        drop_q, drop_d;

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_in
            assign rd_hit[g] = INportRead && (PortSel == SEL_W'(g));

            io_in_channel #(
                .DATA_W(DATA_W)
            ) u_ch (
                .clk      (clk),
                .Reset    (Reset),
                .strobe_i (InpStrobe[g]),
                .data_i   (InpExtWorld[g*DATA_W +: DATA_W]),
                .rd_i     (rd_hit[g]),
                .clr_err_i(ClrErr),
                .data_o   (lat[g]),
                .full_o   (InFull[g]),
                .overrun_o(InOverrun[g])
            );
        end
    endgenerate

    // Read mux; an index with no port behind it reads as zero.
    always_comb begin
        rdata_d = rdata_q;
        if (INportRead) begin
            rdata_d = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (PortSel == SEL_W'(p)) begin
                    rdata_d = lat[p];
                end
            end
        end
    end

    // Busy mirrors the valid flag of the selected output port.
    always_comb begin
        Busy = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (PortSel == SEL_W'(p)) begin
                Busy = valid_q[p];
            end
        end
    end

    // Output handshake: an ack frees the slot for a same-cycle write.
    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        drop_d  = ClrErr ? '0 : drop_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (OUTportWrite && (PortSel == SEL_W'(p))) begin
                if (!valid_q[p] || OutAck[p]) begin
                    out_d[p*DATA_W +: DATA_W] = WriteData;
                    valid_d[p]                = 1'b1;
                end else begin
                    drop_d[p] = 1'b1;
                end
            end else if (OutAck[p]) begin
                valid_d[p] = 1'b0;
            end
        end
    end

    // Processor-side registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rdata_q <= '0;
            out_q   <= '0;
            valid_q <= '0;
            drop_q  <= '0;
        end else begin
            rdata_q <= rdata_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign ReadData    = rdata_q;
    assign OutExtWorld = out_q;
    assign OutValid    = valid_q;
    assign OutDrop     = drop_q;

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed and randomised checks of io_port_bank.
// Event-level reference model with scheduled input captures.
module tb_io_port_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  sel;
    logic        rd, wr, clr;
    logic [7:0]  wd;
    logic [31:0] inp;
    logic [3:0]  stb, ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [3:0]  full, ovr, valid, drop;
    logic [31:0] outw;

    logic [1:0]  sel3;
    logic        rd3, wr3, clr3;
    logic [15:0] wd3;
    logic [47:0] inp3;
    logic [2:0]  stb3, ack3;
    logic [15:0] rdata3;
    logic        busy3;
    logic [2:0]  full3, ovr3, valid3, drop3;
    logic [47:0] outw3;

    io_port_bank dut (
        .clk(clk), .Reset(rst), .PortSel(sel),
        .INportRead(rd), .OUTportWrite(wr), .WriteData(wd),
        .ReadData(rdata), .Busy(busy), .ClrErr(clr),
        .InpExtWorld(inp), .InpStrobe(stb), .InFull(full),
        .InOverrun(ovr), .OutExtWorld(outw), .OutValid(valid),
        .OutAck(ack), .OutDrop(drop)
    );

    io_port_bank #(.DATA_W(16), .NUM_PORTS(3)) dut3 (
        .clk(clk), .Reset(rst), .PortSel(sel3),
        .INportRead(rd3), .OUTportWrite(wr3), .WriteData(wd3),
        .ReadData(rdata3), .Busy(busy3), .ClrErr(clr3),
        .InpExtWorld(inp3), .InpStrobe(stb3), .InFull(full3),
        .InOverrun(ovr3), .OutExtWorld(outw3), .OutValid(valid3),
        .OutAck(ack3), .OutDrop(drop3)
    );

    logic [7:0] m_lat [4];
    logic [7:0] m_out [4];
    logic [7:0] pend_d [4];
    logic [7:0] m_rd;
    bit         m_full [4];
    bit         m_ovr [4];
    bit         m_valid [4];
    bit         m_drop [4];
    int         pend_at [4];
    int         age [4];
    int         cyc;
    int         tests;
    int         fails;

    function automatic logic [3:0] pk(input bit v [4]);
        return {v[3], v[2], v[1], v[0]};
    endfunction

    function automatic void m_reset();
        for (int p = 0; p < 4; p++) begin
            m_lat[p] = '0; m_out[p] = '0;
            m_full[p] = 0; m_ovr[p] = 0;
            m_valid[p] = 0; m_drop[p] = 0;
            pend_at[p] = -1;
        end
        m_rd = '0;
    endfunction

    // One clock edge of the port bank, from its behavioural rules.
    function automatic void model_edge();
        bit cap, reading;
        if (rst) begin
            m_reset();
            return;
        end
        if (rd) m_rd = m_lat[sel];
        if (clr) begin
            for (int p = 0; p < 4; p++) begin
                m_ovr[p] = 0; m_drop[p] = 0;
            end
        end
        for (int p = 0; p < 4; p++) begin
            cap = (pend_at[p] == cyc + 1);
            reading = rd && (int'(sel) == p);
            if (cap) begin
                if (m_full[p] && !reading) m_ovr[p] = 1;
                m_lat[p] = pend_d[p];
                m_full[p] = 1;
                pend_at[p] = -1;
            end else if (reading) begin
                m_full[p] = 0;
            end
            if (wr && (int'(sel) == p)) begin
                if (!m_valid[p] || ack[p]) begin
                    m_out[p] = wd; m_valid[p] = 1;
                end else begin
                    m_drop[p] = 1;
                end
            end else if (ack[p]) begin
                m_valid[p] = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ReadData", rdata, m_rd);
        chk("InFull", full, pk(m_full));
        chk("InOverrun", ovr, pk(m_ovr));
        chk("OutExtWorld", outw, {m_out[3], m_out[2], m_out[1], m_out[0]});
        chk("OutValid", valid, pk(m_valid));
        chk("OutDrop", drop, pk(m_drop));
        chk("Busy", busy, m_valid[sel]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse(input int p, input logic [7:0] d);
        inp[p*8 +: 8] = d;
        stb[p] = 1'b1;
        pend_at[p] = cyc + 3;
        pend_d[p] = d;
        tick(); tick();
        stb[p] = 1'b0;
        tick(); tick();
    endtask

    task automatic rd_port(input int p);
        sel = 2'(p); rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        m_reset();
        for (int p = 0; p < 4; p++) age[p] = -1;

        // Reset with every input driven nonzero.
        rst = 1'b1; sel = 2'd3; rd = 1; wr = 1; clr = 1; wd = 8'hFF;
        inp = '1; stb = '1; ack = '1;
        sel3 = 2'd2; rd3 = 1; wr3 = 1; clr3 = 1; wd3 = '1;
        inp3 = '1; stb3 = '1; ack3 = '1;
        tick(); tick();
        chk("rst_out3", outw3, 48'h0);
        chk("rst_valid3", valid3, 3'b0);
        chk("rst_rdata3", rdata3, 16'h0);
        chk("rst_full3", full3, 3'b0);
        rd = 0; wr = 0; clr = 0; wd = 0; inp = 0; stb = 0; ack = 0;
        sel = 0;
        rd3 = 0; wr3 = 0; clr3 = 0; wd3 = 0; inp3 = 0; stb3 = 0; ack3 = 0;
        sel3 = 0;
        tick();
        rst = 1'b0;
        tick();
        chk("rel_busy", busy, 1'b0);

        // Capture latency on port 1, then read it back.
        inp[15:8] = 8'h0C; stb[1] = 1'b1;
        pend_at[1] = cyc + 3; pend_d[1] = 8'h0C;
        tick(); chk("lat_e1", full[1], 1'b0);
        tick(); chk("lat_e2", full[1], 1'b0);
        tick(); chk("lat_e3", full[1], 1'b1);
        tick();
        stb[1] = 1'b0;
        tick(); tick();
        rd_port(1);
        chk("rd_0C", rdata, 8'h0C);
        chk("rd_clr_full", full[1], 1'b0);

        // Overrun, coincident capture/read, and error clear on port 2.
        pulse(2, 8'h03);
        pulse(2, 8'h3C);
        chk("ovr_set", ovr[2], 1'b1);
        rd_port(2);
        chk("ovr_rd", rdata, 8'h3C);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovr_clr", ovr[2], 1'b0);
        pulse(2, 8'h11);
        inp[23:16] = 8'h22; stb[2] = 1'b1;
        pend_at[2] = cyc + 3; pend_d[2] = 8'h22;
        tick(); tick();
        stb[2] = 1'b0; sel = 2'd2; rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("coin_rd_old", rdata, 8'h11);
        chk("coin_full", full[2], 1'b1);
        chk("coin_no_ovr", ovr[2], 1'b0);
        tick();
        rd_port(2);
        chk("coin_rd_new", rdata, 8'h22);

        // Output handshake on port 0.
        sel = 2'd0; wr = 1'b1; wd = 8'h55;
        tick();
        chk("wr_55", outw[7:0], 8'h55);
        chk("wr_valid", valid[0], 1'b1);
        chk("wr_busy", busy, 1'b1);
        wd = 8'hAA;
        tick();
        chk("drop_data", outw[7:0], 8'h55);
        chk("drop_flag", drop[0], 1'b1);
        ack[0] = 1'b1;
        tick();
        chk("wrack_data", outw[7:0], 8'hAA);
        chk("wrack_valid", valid[0], 1'b1);
        wr = 1'b0;
        tick();
        ack[0] = 1'b0;
        chk("ack_valid", valid[0], 1'b0);
        chk("ack_hold", outw[7:0], 8'hAA);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("drop_clr", drop[0], 1'b0);

        // Reset one cycle after a strobe rise.
        inp[15:8] = 8'h77; stb[1] = 1'b1;
        pend_at[1] = cyc + 3; pend_d[1] = 8'h77;
        tick();
        rst = 1'b1;
        #1;
        m_reset();
        chk("arst_full", full, 4'h0);
        chk("arst_out", outw, 32'h0);
        chk("arst_rdata", rdata, 8'h0);
        stb[1] = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick(); tick();
        chk("arst_nofull", full, 4'h0);
        for (int p = 0; p < 4; p++) begin
            rd_port(p);
            chk("arst_lat", rdata, 8'h0);
        end

        // Three 16-bit ports: index 3 has no port behind it.
        inp3[47:32] = 16'hBEEF; stb3[2] = 1'b1;
        tick(); tick();
        stb3[2] = 1'b0;
        tick(); tick();
        chk("p3_full", full3, 3'b100);
        sel3 = 2'd2; rd3 = 1'b1; tick(); rd3 = 1'b0;
        chk("p3_rd2", rdata3, 16'hBEEF);
        sel3 = 2'd3; rd3 = 1'b1; tick(); rd3 = 1'b0;
        chk("p3_rd3", rdata3, 16'h0);
        wd3 = 16'h1234; wr3 = 1'b1; tick(); wr3 = 1'b0;
        chk("p3_wr3_out", outw3, 48'h0);
        chk("p3_wr3_valid", valid3, 3'b0);
        chk("p3_busy3", busy3, 1'b0);
        sel3 = 2'd2; wd3 = 16'h5678; wr3 = 1'b1; tick(); wr3 = 1'b0;
        chk("p3_wr2_out", outw3, {16'h5678, 32'h0});
        chk("p3_wr2_valid", valid3, 3'b100);

        // Randomised traffic on the default bank.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 4; p++) begin
                if (age[p] == 2) stb[p] = 1'b0;
                if (age[p] >= 4) age[p] = -1;
                if (age[p] < 0 && ($urandom % 3) == 0) begin
                    pend_d[p] = 8'($urandom);
                    inp[p*8 +: 8] = pend_d[p];
                    stb[p] = 1'b1;
                    pend_at[p] = cyc + 3;
                    age[p] = 0;
                end
            end
            sel = 2'($urandom);
            rd = (($urandom % 3) == 0);
            wr = (($urandom % 3) == 0);
            wd = 8'($urandom);
            ack = 4'($urandom) & 4'($urandom);
            clr = (($urandom % 16) == 0);
            tick();
            for (int p = 0; p < 4; p++) begin
                if (age[p] >= 0) age[p]++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised bank of processor-facing I/O ports that replaces the fixed four 8-bit `InpExtWorld`/`OutExtWorld` ports of the RISC processor wrapper.

- Generalises the port count and data width.
- Adds a per-port input capture latch with strobe synchronisation, a new-data flag and overrun detection.
- Adds a per-port output valid/acknowledge handshake with dropped-write detection.
- Sits between the processor's IN/OUT instruction datapath and the external pins.

## Interface
- `DATA_W`, default 8: width of each port.
- `NUM_PORTS`, default 4: number of input ports and number of output ports (equal counts).
- `SEL_W`, default `$clog2(NUM_PORTS)` (minimum 1): port index width.

- `clk`  in  1  single clock; everything is synchronous to its rising edge.
- `Reset`  in  1  reset, asynchronous and active-high.
- `PortSel`  in  SEL_W  processor-side port index.
- `INportRead`  in  1  processor read strobe for input port `PortSel`.
- `OUTportWrite`  in  1  processor write strobe for output port `PortSel`.
- `WriteData`  in  DATA_W  processor write data.
- `ReadData`  out  DATA_W  registered read data.
- `Busy`  out  1  combinational; equals `OutValid[PortSel]`.
- `ClrErr`  in  1  clears all sticky error flags.
- `InpExtWorld`  in  NUM_PORTS*DATA_W  external input data, flattened; port p occupies `[p*DATA_W +: DATA_W]`.
- `InpStrobe`  in  NUM_PORTS  external capture strobes, asynchronous to `clk`.
- `InFull`  out  NUM_PORTS  input latch holds data not yet read.
- `InOverrun`  out  NUM_PORTS  sticky: a capture overwrote unread data.
- `OutExtWorld`  out  NUM_PORTS*DATA_W  output port registers, flattened in the same layout.
- `OutValid`  out  NUM_PORTS  output port holds data not yet acknowledged.
- `OutAck`  in  NUM_PORTS  external acknowledge, synchronous to `clk`.
- `OutDrop`  out  NUM_PORTS  sticky: a processor write was discarded.

## Operation
- **Reset values.** All outputs and internal registers are 0, including the latches, flags, `ReadData`, `OutExtWorld` and the synchroniser flops.
- **Input capture.**
  - Each `InpStrobe[p]` passes through a 2-flop synchroniser followed by a third flop used for rising-edge detection.
  - On a detected rise, the latch loads `InpExtWorld[p]` and `InFull[p]` is set to 1.
  - If `InFull[p]` was already 1 and that port is not being read in the same cycle, `InOverrun[p]` is also set.
- **Processor read.** When `INportRead` is high:
  - `ReadData` loads `latch[PortSel]`, and `InFull[PortSel]` is cleared.
  - A read of an empty port still returns the latch contents and changes no flags.
- **Processor write.** When `OUTportWrite` is high:
  - If `OutValid[PortSel]` is 0, `OutExtWorld[PortSel]` loads `WriteData` and `OutValid[PortSel]` is set to 1.
  - If `OutValid[PortSel]` is 1 with no `OutAck` in the same cycle, the write is discarded: the data is unchanged and `OutDrop[PortSel]` is set.
- **Acknowledge.** An `OutAck[p]` while `OutValid[p]` is 1 clears `OutValid[p]`; `OutExtWorld[p]` keeps its value. An ack while valid is 0 is ignored.
- **Simultaneous events:**
  - Capture and read on the same port: `ReadData` gets the old latch value, the latch loads the new value, `InFull` stays 1, no overrun.
  - Write and ack on the same port while valid: the new data loads, `OutValid` stays 1, no drop.
  - `ClrErr` together with a new error event: the set wins.
  - A read and a write in the same cycle are independent.
- An out-of-range `PortSel` (non-power-of-2 `NUM_PORTS`) makes a read return 0 and a write have no effect.

## Timing
- **Input latency.** If `InpStrobe[p]` rises before clock edge k, `InFull[p]` is 1 after edge k+2.
  - `InpExtWorld[p]` must stay stable from the strobe rise through edge k+2, i.e. at least 3 `clk` periods.
  - The strobe must stay high and then low for at least 2 periods each; shorter pulses may be missed.
- **Read latency.** `ReadData` is valid 1 cycle after `INportRead` and holds its value until the next read.
- **Write latency.** `OutExtWorld` and `OutValid` update 1 cycle after `OUTportWrite`. `Busy` reflects the current `PortSel` in the same cycle.
- **Ack latency.** `OutValid` clears 1 cycle after `OutAck`.
- **Reset mid-operation.** Asserting `Reset` clears everything immediately, including pending captures.

## Structure
- Shared package `io_port_pkg` holds the default `DATA_W` and `NUM_PORTS` constants and a function computing `SEL_W`.
- Sub-module `io_in_channel` contains the synchroniser, edge detect, latch and the `InFull`/`InOverrun` logic for one port. It is instantiated `NUM_PORTS` times in a generate loop.
- Output registers, read mux and `Busy` logic stay in the top level.

## Test plan
- Reset with all inputs nonzero: every output is 0; after release `Busy` = 0.
- Set `InpExtWorld[1]` = 0x0C and pulse `InpStrobe[1]` for 4 cycles: `InFull[1]` = 1 exactly 3 edges after the rise. Then `INportRead` with `PortSel` = 1: the next cycle `ReadData` = 0x0C and `InFull[1]` = 0.
- Two captures on port 2 (0x03, then 0x3C) with no read: `InOverrun[2]` = 1 and a later read returns 0x3C. A capture coinciding with a read gives no overrun. `ClrErr` clears the flag.
- Write 0x55 to port 0: `OutExtWorld[0]` = 0x55 and `OutValid[0]` = 1. A second write of 0xAA without ack is dropped: data stays 0x55 and `OutDrop[0]` = 1. A write of 0xAA together with `OutAck[0]` loads 0xAA with valid held at 1.
- Assert `Reset` mid-capture, one cycle after a strobe rise: no `InFull` afterwards and all latches read 0.
- `NUM_PORTS` = 3, `DATA_W` = 16: a read with `PortSel` = 3 returns 0, and a write with `PortSel` = 3 changes nothing.
